// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - cache-side and memory-side signal bundle of the line port arbiter
// Purpose: groups the icache fill, dcache fill, dcache write-back and memory
//          port signals so the arbiter and its environment share one port.
// Ports (slave = arbiter view):
//   icache fill  : i_ic_rd_req, i_ic_rd_addr -> o_ic_rd_ack, o_ic_rd_data
//   dcache fill  : i_dc_rd_req, i_dc_rd_addr -> o_dc_rd_ack, o_dc_rd_data
//   dcache wb    : i_dc_wb_req, i_dc_wb_addr, i_dc_wb_data -> o_dc_wb_ack
//   memory       : o_mem_address, o_mem_read, o_mem_write, o_mem_wdata
//                  <- i_mem_rdata, i_mem_ready, i_mem_done
//   status       : o_busy
interface mem_port_arbiter_if #(
    parameter int LINE_BITS = 256
);
    logic                 i_ic_rd_req;
    logic [31:0]          i_ic_rd_addr;
    logic                 o_ic_rd_ack;
    logic [LINE_BITS-1:0] o_ic_rd_data;
    logic                 i_dc_rd_req;
    logic [31:0]          i_dc_rd_addr;
    logic                 o_dc_rd_ack;
    logic [LINE_BITS-1:0] o_dc_rd_data;
    logic                 i_dc_wb_req;
    logic [31:0]          i_dc_wb_addr;
    logic [LINE_BITS-1:0] i_dc_wb_data;
    logic                 o_dc_wb_ack;
    logic [31:0]          o_mem_address;
    logic                 o_mem_read;
    logic                 o_mem_write;
    logic [LINE_BITS-1:0] o_mem_wdata;
    logic [LINE_BITS-1:0] i_mem_rdata;
    logic                 i_mem_ready;
    logic                 i_mem_done;
    logic                 o_busy;

    modport slave (
        input  i_ic_rd_req, i_ic_rd_addr, i_dc_rd_req, i_dc_rd_addr,
               i_dc_wb_req, i_dc_wb_addr, i_dc_wb_data,
               i_mem_rdata, i_mem_ready, i_mem_done,
        output o_ic_rd_ack, o_ic_rd_data, o_dc_rd_ack, o_dc_rd_data, o_dc_wb_ack,
               o_mem_address, o_mem_read, o_mem_write, o_mem_wdata, o_busy
    );

    modport master (
        output i_ic_rd_req, i_ic_rd_addr, i_dc_rd_req, i_dc_rd_addr,
               i_dc_wb_req, i_dc_wb_addr, i_dc_wb_data,
               i_mem_rdata, i_mem_ready, i_mem_done,
        input  o_ic_rd_ack, o_ic_rd_data, o_dc_rd_ack, o_dc_rd_data, o_dc_wb_ack,
               o_mem_address, o_mem_read, o_mem_write, o_mem_wdata, o_busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one line-wide memory port between icache and dcache
// Purpose: one line transaction at a time; priority dc_wb > dc_rd > ic_rd,
//          with an ageing counter that lets a starved icache fill jump ahead.
// Ports:
//   i_clock   : rising-edge clock
//   i_reset_n : asynchronous active-low reset
//   bus       : mem_port_arbiter_if.slave (cache requests/acks, memory strobes, o_busy)
module mem_port_arbiter #(
    parameter int AGE_LIMIT = 8,
    parameter int LINE_BITS = 256
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    mem_port_arbiter_if.slave bus
);
    localparam int            AW      = $clog2(AGE_LIMIT + 1);
    localparam logic [AW-1:0] AGE_MAX = AW'(AGE_LIMIT);

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_RESP} state_t;
    typedef enum logic [1:0] {GNT_IC, GNT_DC_RD, GNT_DC_WB} grant_t;

    state_t               state_q;
    grant_t               grant_q;
    logic [AW-1:0]        age_q, age_d;
    logic [31:0]          addr_q;
    logic [LINE_BITS-1:0] wdata_q;
    logic [LINE_BITS-1:0] rdata_q;
    logic                 mem_read_q, mem_write_q;
    logic                 ic_ack_q, dc_rd_ack_q, dc_wb_ack_q;
    logic                 grant_ic, grant_dc_rd, grant_dc_wb;
    logic                 unused_addr_lsbs;

    // Arbitration is evaluated every cycle but only acted on in IDLE.
    // dc_rd is masked by a pending write-back so a dirty line always reaches
    // memory before the refill of the same set.
    always_comb begin
        grant_ic    = bus.i_ic_rd_req &&
                      ((age_q == AGE_MAX) || (!bus.i_dc_wb_req && !bus.i_dc_rd_req));
        grant_dc_wb = bus.i_dc_wb_req && !grant_ic;
        grant_dc_rd = bus.i_dc_rd_req && !bus.i_dc_wb_req && !grant_ic;

        age_d = age_q;
        if (!bus.i_ic_rd_req || (state_q == ST_IDLE && grant_ic)) begin
            age_d = '0;
        end else if (age_q != AGE_MAX) begin
            age_d = age_q + 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= GNT_IC;
            age_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            ic_ack_q    <= 1'b0;
            dc_rd_ack_q <= 1'b0;
            dc_wb_ack_q <= 1'b0;
        end else begin
            age_q       <= age_d;
            ic_ack_q    <= 1'b0;
            dc_rd_ack_q <= 1'b0;
            dc_wb_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_dc_wb) begin
                        grant_q     <= GNT_DC_WB;
                        addr_q      <= {bus.i_dc_wb_addr[31:5], 5'b0};
                        wdata_q     <= bus.i_dc_wb_data;
                        mem_write_q <= 1'b1;
                        state_q     <= ST_WR;
                    end else if (grant_dc_rd) begin
                        grant_q    <= GNT_DC_RD;
                        addr_q     <= {bus.i_dc_rd_addr[31:5], 5'b0};
                        mem_read_q <= 1'b1;
                        state_q    <= ST_RD;
                    end else if (grant_ic) begin
                        grant_q    <= GNT_IC;
                        addr_q     <= {bus.i_ic_rd_addr[31:5], 5'b0};
                        mem_read_q <= 1'b1;
                        state_q    <= ST_RD;
                    end
                end
                ST_RD: begin
                    // i_mem_done is meaningless here and deliberately ignored.
                    if (bus.i_mem_ready) begin
                        rdata_q    <= bus.i_mem_rdata;
                        mem_read_q <= 1'b0;
                        state_q    <= ST_RESP;
                        if (grant_q == GNT_IC) begin
                            ic_ack_q <= 1'b1;
                        end else begin
                            dc_rd_ack_q <= 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    if (bus.i_mem_done) begin
                        mem_write_q <= 1'b0;
                        dc_wb_ack_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                default: begin
                    // RESP: the ack registered on entry is visible for this one cycle.
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_mem_address = addr_q;
    assign bus.o_mem_read    = mem_read_q;
    assign bus.o_mem_write   = mem_write_q;
    assign bus.o_mem_wdata   = wdata_q;
    assign bus.o_ic_rd_ack   = ic_ack_q;
    assign bus.o_dc_rd_ack   = dc_rd_ack_q;
    assign bus.o_dc_wb_ack   = dc_wb_ack_q;
    // Both caches see the last captured line; only the acked one consumes it.
    assign bus.o_ic_rd_data  = rdata_q;
    assign bus.o_dc_rd_data  = rdata_q;
    assign bus.o_busy        = (state_q != ST_IDLE);

    // Line offsets are forced to zero on the memory side.
    assign unused_addr_lsbs = ^{bus.i_ic_rd_addr[4:0], bus.i_dc_rd_addr[4:0],
                                bus.i_dc_wb_addr[4:0]};
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomised checks of mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int LB = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.LINE_BITS(LB)) bus();

    mem_port_arbiter #(.AGE_LIMIT(8), .LINE_BITS(LB)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [LB-1:0] line_init(input int i);
        return {8{32'hC0DE_0000 + 32'(i)}};
    endfunction

    // Memory side: either the automatic responder or manual drive from the main sequence.
    int            lat     = 1;
    bit            resp_en = 1'b1;
    logic          rsp_ready, rsp_done, man_ready, man_done;
    logic [LB-1:0] rsp_rdata, man_rdata;
    logic [LB-1:0] mem [8];
    logic [LB-1:0] exp_mem [8];

    assign bus.i_mem_ready = resp_en ? rsp_ready : man_ready;
    assign bus.i_mem_done  = resp_en ? rsp_done  : man_done;
    assign bus.i_mem_rdata = resp_en ? rsp_rdata : man_rdata;

    initial begin
        int cnt;
        for (int i = 0; i < 8; i++) mem[i] = line_init(i);
        rsp_ready = 1'b0; rsp_done = 1'b0; rsp_rdata = '0; cnt = 0;
        forever begin
            @(negedge clk);
            rsp_ready = 1'b0;
            rsp_done  = 1'b0;
            if (bus.o_mem_read || bus.o_mem_write) begin
                if (cnt >= lat - 1) begin
                    cnt = 0;
                    if (bus.o_mem_read) begin
                        rsp_rdata = mem[bus.o_mem_address[7:5]];
                        rsp_ready = 1'b1;
                    end else begin
                        mem[bus.o_mem_address[7:5]] = bus.o_mem_wdata;
                        rsp_done = 1'b1;
                    end
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    int viol = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (bus.o_mem_read && bus.o_mem_write) viol++;
            if (32'(bus.o_ic_rd_ack) + 32'(bus.o_dc_rd_ack) + 32'(bus.o_dc_wb_ack) > 1) viol++;
        end
    end

    int            ic_acks, dc_acks, wb_acks, dc_pos, wb_pos, first_ack;
    logic [LB-1:0] ic_data, dc_data;

    // Runs until all raised requests are acked and the arbiter is back in IDLE.
    task automatic run_until_idle(input int budget, output bit ok);
        ok = 1'b0; ic_acks = 0; dc_acks = 0; wb_acks = 0;
        dc_pos = -1; wb_pos = -1; first_ack = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (bus.o_ic_rd_ack) begin
                ic_acks++; ic_data = bus.o_ic_rd_data; bus.i_ic_rd_req = 1'b0;
                if (first_ack < 0) first_ack = 0;
            end
            if (bus.o_dc_rd_ack) begin
                dc_acks++; dc_data = bus.o_dc_rd_data; dc_pos = n; bus.i_dc_rd_req = 1'b0;
                if (first_ack < 0) first_ack = 1;
            end
            if (bus.o_dc_wb_ack) begin
                wb_acks++; wb_pos = n; bus.i_dc_wb_req = 1'b0;
                if (first_ack < 0) first_ack = 2;
            end
            if (!bus.i_ic_rd_req && !bus.i_dc_rd_req && !bus.i_dc_wb_req && !bus.o_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit            ok;
        int            ack_n, dc_cnt, ic_grant_n;
        logic [2:0]    mask;
        int            ia, da, wa;
        logic [LB-1:0] wdat;
        logic [LB-1:0] pat_b, pat_c, pat_d;

        pat_b = {8{32'hBBBB_0100}};
        pat_c = {8{32'hCCCC_0020}};
        pat_d = {8{32'hDDDD_0060}};
        for (int i = 0; i < 8; i++) exp_mem[i] = line_init(i);
        bus.i_ic_rd_req = 1'b0; bus.i_ic_rd_addr = '0;
        bus.i_dc_rd_req = 1'b0; bus.i_dc_rd_addr = '0;
        bus.i_dc_wb_req = 1'b0; bus.i_dc_wb_addr = '0; bus.i_dc_wb_data = '0;
        man_ready = 1'b0; man_done = 1'b0; man_rdata = '0;

        // Reset state
        @(negedge clk); @(negedge clk);
        check("rst_busy", bus.o_busy, 1'b0);
        check("rst_strobes", {bus.o_mem_read, bus.o_mem_write}, 2'b00);
        check("rst_acks", {bus.o_ic_rd_ack, bus.o_dc_rd_ack, bus.o_dc_wb_ack}, 3'b000);
        check("rst_addr", bus.o_mem_address, 32'h0);
        check("rst_rdata", bus.o_ic_rd_data, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single icache fill, memory latency 4
        lat = 4;
        bus.i_ic_rd_addr = 32'h0000_1234; bus.i_ic_rd_req = 1'b1;
        @(negedge clk);
        check("ic_read_strobe", bus.o_mem_read, 1'b1);
        check("ic_addr_aligned", bus.o_mem_address, 32'h0000_1220);
        ack_n = 0;
        for (int n = 2; n <= 30; n++) begin
            @(negedge clk);
            if (bus.o_ic_rd_ack) begin ack_n = n; break; end
        end
        check("ic_ack_cycle", ack_n, 5);
        check("ic_data", bus.o_ic_rd_data, line_init(1));
        bus.i_ic_rd_req = 1'b0;
        @(negedge clk);
        check("ic_ack_single", bus.o_ic_rd_ack, 1'b0);
        check("ic_back_idle", bus.o_busy, 1'b0);

        // Write-back and refill of the same line raised together
        lat = 1;
        bus.i_dc_wb_addr = 32'h100; bus.i_dc_wb_data = pat_b; bus.i_dc_wb_req = 1'b1;
        bus.i_dc_rd_addr = 32'h100; bus.i_dc_rd_req = 1'b1;
        exp_mem[0] = pat_b;
        @(negedge clk);
        check("wb_first_strobe", {bus.o_mem_write, bus.o_mem_read}, 2'b10);
        check("wb_wdata", bus.o_mem_wdata, pat_b);
        check("wb_addr", bus.o_mem_address, 32'h100);
        run_until_idle(30, ok);
        check("wbrd_done", ok, 1'b1);
        check("wbrd_first_ack_wb", first_ack, 2);
        check("wbrd_counts", {8'(wb_acks), 8'(dc_acks), 8'(ic_acks)}, 24'h010100);
        check("wbrd_refill_data", dc_data, pat_b);

        // Ageing: dcache keeps re-requesting, icache must get through
        lat = 1;
        bus.i_dc_rd_addr = 32'h40; bus.i_ic_rd_addr = 32'h80;
        bus.i_dc_rd_req = 1'b1; bus.i_ic_rd_req = 1'b1;
        dc_cnt = 0; ic_grant_n = -1; ok = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.o_mem_read && bus.o_mem_address == 32'h80 && ic_grant_n < 0) ic_grant_n = n;
            if (bus.o_dc_rd_ack) dc_cnt++;
            if (bus.o_ic_rd_ack) begin
                ok = 1'b1; ic_data = bus.o_ic_rd_data;
                bus.i_ic_rd_req = 1'b0; bus.i_dc_rd_req = 1'b0;
                break;
            end
        end
        check("age_ic_acked", ok, 1'b1);
        check("age_dc_before_ic", dc_cnt, 3);
        check("age_ic_grant_cycle", ic_grant_n, 10);
        check("age_ic_data", ic_data, line_init(4));
        run_until_idle(10, ok);
        check("age_drain", ok, 1'b1);

        // Wrong-kind completion strobes are ignored
        resp_en = 1'b0;
        bus.i_ic_rd_addr = 32'h20; bus.i_ic_rd_req = 1'b1;
        @(negedge clk);
        check("ign_rd_started", bus.o_mem_read, 1'b1);
        man_done = 1'b1;
        @(negedge clk);
        check("ign_done_in_rd", {bus.o_mem_read, bus.o_mem_write, bus.o_busy, bus.o_ic_rd_ack}, 4'b1010);
        man_done = 1'b0; man_rdata = pat_c; man_ready = 1'b1;
        @(negedge clk);
        check("ign_rd_ack", bus.o_ic_rd_ack, 1'b1);
        check("ign_rd_data", bus.o_ic_rd_data, pat_c);
        man_ready = 1'b0; bus.i_ic_rd_req = 1'b0;
        @(negedge clk);
        bus.i_dc_wb_addr = 32'h60; bus.i_dc_wb_data = pat_d; bus.i_dc_wb_req = 1'b1;
        exp_mem[3] = pat_d;
        @(negedge clk);
        check("ign_wr_started", bus.o_mem_write, 1'b1);
        man_ready = 1'b1;
        @(negedge clk);
        check("ign_ready_in_wr", {bus.o_mem_write, bus.o_mem_read, bus.o_busy, bus.o_dc_wb_ack}, 4'b1010);
        man_ready = 1'b0; man_done = 1'b1;
        @(negedge clk);
        check("ign_wb_ack", bus.o_dc_wb_ack, 1'b1);
        man_done = 1'b0; bus.i_dc_wb_req = 1'b0;
        @(negedge clk);
        check("ign_idle", bus.o_busy, 1'b0);

        // Reset in the middle of a read
        bus.i_dc_rd_addr = 32'hE4; bus.i_dc_rd_req = 1'b1;
        @(negedge clk);
        check("rstm_read_on", bus.o_mem_read, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rstm_async_clear",
              {bus.o_mem_read, bus.o_mem_write, bus.o_busy, bus.o_ic_rd_ack, bus.o_dc_rd_ack, bus.o_dc_wb_ack},
              6'b0);
        @(negedge clk);
        check("rstm_no_ack", {bus.o_ic_rd_ack, bus.o_dc_rd_ack, bus.o_dc_wb_ack}, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstm_regrant", {bus.o_mem_read, bus.o_mem_address}, {1'b1, 32'hE0});
        lat = 2; resp_en = 1'b1;
        run_until_idle(30, ok);
        check("rstm_done", ok, 1'b1);
        check("rstm_one_ack", dc_acks, 1);
        check("rstm_data", dc_data, line_init(7));

        // Random request mixes against the memory model
        for (int it = 0; it < 2000; it++) begin
            mask = 3'($urandom_range(1, 7));
            lat  = $urandom_range(1, 3);
            ia = $urandom_range(0, 7); da = $urandom_range(0, 7); wa = $urandom_range(0, 7);
            for (int w = 0; w < 8; w++) wdat[w*32 +: 32] = $urandom;
            bus.i_ic_rd_addr = ($urandom & 32'hFFFF_FF1F) | (32'(ia) << 5);
            bus.i_dc_rd_addr = ($urandom & 32'hFFFF_FF1F) | (32'(da) << 5);
            bus.i_dc_wb_addr = ($urandom & 32'hFFFF_FF1F) | (32'(wa) << 5);
            bus.i_dc_wb_data = wdat;
            bus.i_ic_rd_req = mask[0]; bus.i_dc_rd_req = mask[1]; bus.i_dc_wb_req = mask[2];
            if (mask[2]) exp_mem[wa] = wdat;
            run_until_idle(60, ok);
            check("rnd_done", ok, 1'b1);
            check("rnd_ack_counts", {8'(wb_acks), 8'(dc_acks), 8'(ic_acks)},
                  {8'(mask[2]), 8'(mask[1]), 8'(mask[0])});
            if (mask[0]) check("rnd_ic_data", ic_data, exp_mem[ia]);
            if (mask[1]) check("rnd_dc_data", dc_data, exp_mem[da]);
            if (mask[1] && mask[2]) check("rnd_wb_before_rd", wb_pos < dc_pos, 1'b1);
        end

        check("strobe_ack_exclusive", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
